// File: rtl/fifo_mult_reader_pkg.sv
// Shared definitions for the fifo_mult_reader operand consumer: FSM encoding,
// default widths and the operand-pair packing layout.
package fifo_mult_reader_pkg;

    localparam int unsigned OP_W_DEF  = 8;
    localparam int unsigned CNT_W_DEF = 4;

    // Field index within a packed pair; the field starts at index*OP_W
    localparam int unsigned A_FIELD = 1;
    localparam int unsigned B_FIELD = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WAIT,
        ST_CALC,
        ST_DONE
    } state_t;

endpackage

// File: rtl/fifo_mult_reader_mult_shift_add.sv
// Shift-add multiplier core: operand registers, accumulator and iteration counter.
// Define MULT_SIGNED_EN for two's-complement operands (magnitude multiply plus sign fix).
module mult_shift_add
    import fifo_mult_reader_pkg::*;
#(
    parameter int unsigned OP_W  = OP_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                step,
    input  logic [OP_W-1:0]     a_op,
    input  logic [OP_W-1:0]     b_op,
    output logic                last,
    output logic [2*OP_W-1:0]   result
);

    localparam int unsigned P_W = 2 * OP_W;

    logic [P_W-1:0]   a_q;
    logic [P_W-1:0]   acc_q;
    logic [OP_W-1:0]  b_q;
    logic [CNT_W-1:0] cnt_q;
    logic [OP_W-1:0]  a_mag;
    logic [OP_W-1:0]  b_mag;
    logic [P_W-1:0]   sum_c;

`ifdef MULT_SIGNED_EN
    logic neg_q;

    // Magnitude of the most negative value still fits as an unsigned OP_W number
    assign a_mag = a_op[OP_W-1] ? OP_W'(-a_op) : a_op;
    assign b_mag = b_op[OP_W-1] ? OP_W'(-b_op) : b_op;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
        end else if (start) begin
            neg_q <= a_op[OP_W-1] ^ b_op[OP_W-1];
        end
    end

    assign result = neg_q ? P_W'(-sum_c) : sum_c;
`else
    assign a_mag  = a_op;
    assign b_mag  = b_op;
    assign result = sum_c;
`endif

    // Accumulator value after the current iteration; used for the final update too
    assign sum_c = b_q[0] ? acc_q + a_q : acc_q;
    assign last  = (cnt_q == CNT_W'(OP_W - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (start) begin
            a_q   <= P_W'(a_mag);
            b_q   <= b_mag;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (step) begin
            acc_q <= sum_c;
            a_q   <= a_q << 1;
            b_q   <= b_q >> 1;
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fifo_mult_reader.sv
// FIFO read-side consumer: pops {A,B} pairs and produces A*B with a done strobe.
// Define MULT_SIGNED_EN for two's-complement multiplication.
module fifo_mult_reader
    import fifo_mult_reader_pkg::*;
#(
    parameter int unsigned OP_W  = OP_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic                CLK,
    input  logic                RSTn,
    input  logic                Empty_Sig,
    input  logic [2*OP_W-1:0]   FIFO_Read_Data,
    output logic                Read_Req,
    output logic                Busy_Sig,
    output logic                Done_Sig,
    output logic [2*OP_W-1:0]   Product
);

    state_t            state_q;
    state_t            state_d;
    logic              read_req_d;
    logic              busy_d;
    logic              done_d;
    logic [2*OP_W-1:0] product_d;
    logic              start;
    logic              step;
    logic              last;
    logic [2*OP_W-1:0] result;

    mult_shift_add #(
        .OP_W  (OP_W),
        .CNT_W (CNT_W)
    ) u_mult (
        .clk    (CLK),
        .rst_n  (RSTn),
        .start  (start),
        .step   (step),
        .a_op   (FIFO_Read_Data[A_FIELD*OP_W +: OP_W]),
        .b_op   (FIFO_Read_Data[B_FIELD*OP_W +: OP_W]),
        .last   (last),
        .result (result)
    );

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q  <= ST_IDLE;
            Read_Req <= 1'b0;
            Busy_Sig <= 1'b0;
            Done_Sig <= 1'b0;
            Product  <= '0;
        end else begin
            state_q  <= state_d;
            Read_Req <= read_req_d;
            Busy_Sig <= busy_d;
            Done_Sig <= done_d;
            Product  <= product_d;
        end
    end

    // Next state, handshake and datapath control
    always_comb begin
        state_d    = state_q;
        read_req_d = 1'b0;
        done_d     = 1'b0;
        product_d  = Product;
        start      = 1'b0;
        step       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!Empty_Sig) begin
                    read_req_d = 1'b1;
                    state_d    = ST_RD;
                end
            end
            ST_RD: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                start   = 1'b1;
                state_d = ST_CALC;
            end
            ST_CALC: begin
                step = 1'b1;
                if (last) begin
                    product_d = result;
                    done_d    = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

endmodule

// File: tb/tb_fifo_mult_reader.sv
// Scoreboard bench for fifo_mult_reader: FIFO model plus arithmetic reference.
// Honours MULT_SIGNED_EN to select the signed reference model.
module tb_fifo_mult_reader;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        Empty_Sig = 1'b1;
    logic [15:0] FIFO_Read_Data = '0;
    logic        Read_Req;
    logic        Busy_Sig;
    logic        Done_Sig;
    logic [15:0] Product;

    fifo_mult_reader dut (
        .CLK            (CLK),
        .RSTn           (RSTn),
        .Empty_Sig      (Empty_Sig),
        .FIFO_Read_Data (FIFO_Read_Data),
        .Read_Req       (Read_Req),
        .Busy_Sig       (Busy_Sig),
        .Done_Sig       (Done_Sig),
        .Product        (Product)
    );

    always #5 CLK = ~CLK;

    logic [15:0] fifo_q[$];
    logic [15:0] exp_q[$];
    int          exp_rd = 0;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          gap_arm = 0;
    int          b2b_arm = 0;
    bit          b2b_on = 1'b0;
    bit          idle_chk = 1'b0;

    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b);
        int p;
`ifdef MULT_SIGNED_EN
        p = int'($signed(a)) * int'($signed(b));
`else
        p = int'(a) * int'(b);
`endif
        return 16'(p);
    endfunction

    // One cycle: at the falling edge the FIFO serves a pending pop and updates its flag
    task automatic tick();
        @(negedge CLK);
        if (Read_Req && fifo_q.size() != 0) FIFO_Read_Data = fifo_q.pop_front();
        Empty_Sig = (fifo_q.size() == 0);
    endtask

    task automatic push_exp(input logic [7:0] a, input logic [7:0] b, input logic [15:0] e);
        fifo_q.push_back({a, b});
        exp_q.push_back(e);
        Empty_Sig = 1'b0;
    endtask

    task automatic push_noexp(input logic [7:0] a, input logic [7:0] b);
        fifo_q.push_back({a, b});
        Empty_Sig = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (fifo_q.size() != 0 || exp_rd != exp_q.size() || Busy_Sig) begin
            tick();
            n++;
            if (n > 2000) begin
                $display("FAIL drain_timeout: pending=%0d busy=%b, required idle within 2000 cycles",
                         exp_q.size() - exp_rd, Busy_Sig);
                $fatal(1, "drain stalled");
            end
        end
        repeat (2) tick();
    endtask

    task automatic wait_sig(input bit want_done);
        int n = 0;
        while (want_done ? !Done_Sig : !Busy_Sig) begin
            tick();
            n++;
            if (n > 200) begin
                $display("FAIL wait_timeout: done=%b busy=%b, required event within 200 cycles",
                         Done_Sig, Busy_Sig);
                $fatal(1, "wait stalled");
            end
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge and owns all comparisons
    initial begin : monitor
        int          rr_cyc, done_cyc, gap_seen, b2b_seen;
        bit          rr_valid, done_valid, prev_rr, prev_done;
        logic [15:0] prod_model, e;
        rr_cyc = 0; done_cyc = 0; gap_seen = 0; b2b_seen = 0;
        rr_valid = 0; done_valid = 0; prev_rr = 0; prev_done = 0;
        prod_model = '0;
        forever begin
            @(posedge CLK);
            #1;
            cyc++;
            if (!RSTn) begin
                checks++;
                if (Read_Req !== 1'b0 || Busy_Sig !== 1'b0 || Done_Sig !== 1'b0 || Product !== 16'h0) begin
                    errors++;
                    $display("FAIL reset_outputs: rr=%b busy=%b done=%b product=%h, required all zero",
                             Read_Req, Busy_Sig, Done_Sig, Product);
                end
                prod_model = '0; rr_valid = 0; done_valid = 0; prev_rr = 0; prev_done = 0;
            end else begin
                if (idle_chk) begin
                    checks++;
                    if (Read_Req !== 1'b0 || Busy_Sig !== 1'b0 || Product !== prod_model) begin
                        errors++;
                        $display("FAIL idle_hold: rr=%b busy=%b product=%h, required 0 0 %h",
                                 Read_Req, Busy_Sig, Product, prod_model);
                    end
                end
                if (Read_Req === 1'b1) begin
                    checks++;
                    if (prev_rr || Empty_Sig) begin
                        errors++;
                        $display("FAIL read_req_pulse: consecutive=%b empty=%b, required 0 0",
                                 prev_rr, Empty_Sig);
                    end
                    if (gap_arm != gap_seen) begin
                        checks++;
                        if (cyc - done_cyc != 2) begin
                            errors++;
                            $display("FAIL done_to_read_req: %0d cycles, required 2", cyc - done_cyc);
                        end
                        gap_seen = gap_arm;
                    end
                    rr_cyc = cyc; rr_valid = 1;
                end
                if (Done_Sig === 1'b1) begin
                    checks++;
                    if (prev_done) begin
                        errors++;
                        $display("FAIL done_pulse: done high for consecutive cycles, required one cycle");
                    end
                    checks++;
                    if (exp_rd >= exp_q.size()) begin
                        errors++;
                        $display("FAIL unexpected_done: product=%h, required no Done_Sig", Product);
                    end else begin
                        e = exp_q[exp_rd];
                        exp_rd++;
                        prod_model = e;
                        if (Product !== e) begin
                            errors++;
                            $display("FAIL product: got %h, required %h", Product, e);
                        end
                    end
                    if (rr_valid) begin
                        checks++;
                        if (cyc - rr_cyc != 10) begin
                            errors++;
                            $display("FAIL latency: %0d cycles, required 10", cyc - rr_cyc);
                        end
                        rr_valid = 0;
                    end
                    if (b2b_on) begin
                        if (b2b_seen == b2b_arm && done_valid) begin
                            checks++;
                            if (cyc - done_cyc != 12) begin
                                errors++;
                                $display("FAIL throughput: %0d cycles between done, required 12", cyc - done_cyc);
                            end
                        end
                        b2b_seen = b2b_arm;
                    end
                    done_cyc = cyc; done_valid = 1;
                end
                prev_rr = (Read_Req === 1'b1);
                prev_done = (Done_Sig === 1'b1);
            end
        end
    end

    initial begin : stimulus
        logic [7:0] a, b;
        repeat (3) tick();
        RSTn = 1'b1;
        tick();

        // Back-to-back pairs queued together
        b2b_arm++;
        b2b_on = 1'b1;
        push_exp(8'd12, 8'd9, 16'd108);
        push_exp(8'd33, 8'd10, 16'd330);
        push_exp(8'd40, 8'd5, 16'd200);
        drain();
        b2b_on = 1'b0;

        push_exp(8'd127, 8'd127, 16'h3F01);
        push_exp(8'd0, 8'd200, 16'h0000);
`ifdef MULT_SIGNED_EN
        push_exp(8'hFF, 8'h02, 16'hFFFE);
        push_exp(8'h80, 8'h80, 16'h4000);
        push_exp(8'h7F, 8'h81, 16'hC0FF);
`else
        push_exp(8'd255, 8'd255, 16'hFE01);
        push_exp(8'hFF, 8'h02, 16'h01FE);
`endif
        drain();

        // Long empty period: no pops, product held
        idle_chk = 1'b1;
        repeat (50) tick();
        idle_chk = 1'b0;

        // Reset during CALC abandons the pair
        push_noexp(8'd37, 8'd21);
        wait_sig(1'b0);
        repeat (5) tick();
        RSTn = 1'b0;
        tick();
        RSTn = 1'b1;
        repeat (20) tick();
        push_exp(8'd9, 8'd8, 16'd72);
        drain();

        // Next pair arrives while Done_Sig is high
        push_exp(8'd7, 8'd11, 16'd77);
        wait_sig(1'b1);
        gap_arm++;
        push_exp(8'd25, 8'd4, 16'd100);
        drain();

        // Randomised pairs with random arrival gaps
        for (int i = 0; i < 60; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) a = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
            if ($urandom_range(0, 7) == 0) b = ($urandom_range(0, 1) == 0) ? 8'h80 : 8'hFF;
            push_exp(a, b, model(a, b));
            repeat ($urandom_range(0, 14)) tick();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
